// File: rtl/cascade_comp_ctrl_pkg.sv
// Shared types for the nibble-serial magnitude comparator: FSM states, nibble result
// encoding and the helpers that size the nibble sequencer.
package comp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    NibEq = 2'b00,
    NibLs = 2'b01,
    NibGt = 2'b10
  } nib_res_e;

  function automatic int unsigned nibbles(input int unsigned width);
    return width / 4;
  endfunction

  // idx needs at least one bit even for a single-nibble operand.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cascade_comp_ctrl_if.sv
// Start/busy/done handshake and result flags of cascade_comp_ctrl.
// master drives the operands, slave is the controller.
interface cascade_comp_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             a_eq_b;
  logic             a_ls_b;
  logic             a_gt_b;

  modport master (
    output start, a, b,
    input  busy, done, a_eq_b, a_ls_b, a_gt_b
  );

  modport slave (
    input  start, a, b,
    output busy, done, a_eq_b, a_ls_b, a_gt_b
  );
endinterface

// File: rtl/cascade_comp_ctrl_nibble_comp.sv
// Combinational 4-bit unsigned magnitude comparator returning the comp_pkg encoding.
module nibble_comp
  import comp_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output nib_res_e   res_o
);

  always_comb begin
    res_o = NibEq;
    if (a_i > b_i) begin
      res_o = NibGt;
    end else if (a_i < b_i) begin
      res_o = NibLs;
    end
  end

endmodule

// File: rtl/cascade_comp_ctrl.sv
// Nibble-serial WIDTH-bit unsigned comparator, MSB nibble first, one shared 4-bit stage.
// Define CASCADE_COMP_EARLY_EXIT_EN to stop scanning at the first unequal nibble.
module cascade_comp_ctrl
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  cascade_comp_ctrl_if.slave bus
);

  localparam int unsigned NIBBLES = nibbles(WIDTH);
  localparam int unsigned IdxW    = idx_width(NIBBLES);

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  nib_res_e         dec_q, dec_d;
  logic             eq_q, eq_d;
  logic             ls_q, ls_d;
  logic             gt_q, gt_d;

  logic [WIDTH-1:0] a_sh, b_sh;
  nib_res_e         cmp_res;
  nib_res_e         res_now;
  logic             last;

  assign a_sh = a_q >> {idx_q, 2'b00};
  assign b_sh = b_q >> {idx_q, 2'b00};

  nibble_comp u_nibble_comp (
    .a_i   (a_sh[3:0]),
    .b_i   (b_sh[3:0]),
    .res_o (cmp_res)
  );

  // A decided result is sticky; lower nibbles cannot override it.
  assign res_now = (dec_q != NibEq) ? dec_q : cmp_res;

`ifdef CASCADE_COMP_EARLY_EXIT_EN
  assign last = (idx_q == '0) || (res_now != NibEq);
`else
  assign last = (idx_q == '0);
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    dec_d   = dec_q;
    eq_d    = eq_q;
    ls_d    = ls_q;
    gt_d    = gt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StScan;
          a_d     = bus.a;
          b_d     = bus.b;
          idx_d   = IdxW'(NIBBLES - 1);
          dec_d   = NibEq;
          eq_d    = 1'b0;
          ls_d    = 1'b0;
          gt_d    = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StScan: begin
        dec_d = res_now;
        if (last) begin
          state_d = StDone;
          eq_d    = (res_now == NibEq);
          ls_d    = (res_now == NibLs);
          gt_d    = (res_now == NibGt);
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dec_q   <= NibEq;
      eq_q    <= 1'b0;
      ls_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dec_q   <= dec_d;
      eq_q    <= eq_d;
      ls_q    <= ls_d;
      gt_q    <= gt_d;
    end
  end

  assign bus.busy   = (state_q == StScan);
  assign bus.done   = (state_q == StDone);
  assign bus.a_eq_b = eq_q;
  assign bus.a_ls_b = ls_q;
  assign bus.a_gt_b = gt_q;

endmodule

// File: tb/tb_cascade_comp_ctrl.sv
// Self-checking bench for cascade_comp_ctrl (WIDTH=16): vector table, scoreboard queue,
// and hand-written sequences for busy-start, back-to-back launch and mid-scan reset.
module tb_cascade_comp_ctrl;

  localparam int unsigned W  = 16;
  localparam int unsigned NN = W / 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         eq;
    logic         ls;
    logic         gt;
  } vec_t;

  typedef struct {
    logic eq;
    logic ls;
    logic gt;
    int   lat;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  exp_t sb[$];
  vec_t vecs[7];

  cascade_comp_ctrl_if #(.WIDTH(W)) bus ();

  cascade_comp_ctrl #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Edges from the accepting edge until done is seen.
  function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef CASCADE_COMP_EARLY_EXIT_EN
    logic [W-1:0] x;
    x = a ^ b;
    for (int j = 0; j < NN; j++) begin
      if (x[W-1-4*j -: 4] != 4'h0) return j + 1;
    end
`endif
    return NN;
  endfunction

  function automatic exp_t make_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic eq, input logic ls, input logic gt);
    exp_t e;
    e.eq  = eq;
    e.ls  = ls;
    e.gt  = gt;
    e.lat = exp_latency(a, b);
    return e;
  endfunction

  task automatic wait_done(input int max, output int edges, output bit ok);
    edges = 0;
    ok    = 1'b0;
    while (edges < max) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_result(input string name, input int edges, input bit ok,
                              input int lat_adj);
    exp_t e;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done", name);
      return;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb: got empty scoreboard expected entry", name);
      return;
    end
    e = sb.pop_front();
    chk({name, "_eq"}, int'(bus.a_eq_b), int'(e.eq));
    chk({name, "_ls"}, int'(bus.a_ls_b), int'(e.ls));
    chk({name, "_gt"}, int'(bus.a_gt_b), int'(e.gt));
    chk({name, "_lat"}, edges, e.lat - lat_adj);
    chk({name, "_busy_in_done"}, int'(bus.busy), 0);
  endtask

  task automatic run_op(input string name, input vec_t v);
    int edges;
    bit ok;
    sb.push_back(make_exp(v.a, v.b, v.eq, v.ls, v.gt));
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = v.a;
    bus.b     = v.b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({name, "_busy"}, int'(bus.busy), 1);
    chk({name, "_cleared"}, int'({bus.a_eq_b, bus.a_ls_b, bus.a_gt_b}), 0);
    wait_done(20, edges, ok);
    check_result(name, edges, ok, 0);
    @(posedge clk);
    #1;
    chk({name, "_done_drop"}, int'(bus.done), 0);
    chk({name, "_hold"}, int'({bus.a_eq_b, bus.a_ls_b, bus.a_gt_b}),
        int'({v.eq, v.ls, v.gt}));
  endtask

  initial begin
    int edges;
    bit ok;
    int pulses;
    errors = 0;
    checks = 0;

    vecs[0] = '{a: 16'h1234, b: 16'h1234, eq: 1'b1, ls: 1'b0, gt: 1'b0};
    vecs[1] = '{a: 16'h8000, b: 16'h7FFF, eq: 1'b0, ls: 1'b0, gt: 1'b1};
    vecs[2] = '{a: 16'h1233, b: 16'h1234, eq: 1'b0, ls: 1'b1, gt: 1'b0};
    vecs[3] = '{a: 16'h0000, b: 16'hFFFF, eq: 1'b0, ls: 1'b1, gt: 1'b0};
    vecs[4] = '{a: 16'hFFFF, b: 16'hFFFF, eq: 1'b1, ls: 1'b0, gt: 1'b0};
    vecs[5] = '{a: 16'h0F00, b: 16'h0E00, eq: 1'b0, ls: 1'b0, gt: 1'b1};
    vecs[6] = '{a: 16'h00A0, b: 16'h00B0, eq: 1'b0, ls: 1'b1, gt: 1'b0};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", int'({bus.busy, bus.done, bus.a_eq_b, bus.a_ls_b, bus.a_gt_b}), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Start pulsed during SCAN is ignored; start in DONE launches back-to-back.
    sb.push_back(make_exp(16'd1, 16'd2, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'd1;
    bus.b     = 16'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'h0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("ign_busy", int'(bus.busy), 1);
    wait_done(20, edges, ok);
    check_result("ign", edges, ok, 1);
    sb.push_back(make_exp(16'd5, 16'd5, 1'b1, 1'b0, 1'b0));
    bus.start = 1'b1;
    bus.a     = 16'd5;
    bus.b     = 16'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b_busy", int'(bus.busy), 1);
    chk("b2b_cleared", int'({bus.a_eq_b, bus.a_ls_b, bus.a_gt_b}), 0);
    wait_done(20, edges, ok);
    check_result("b2b", edges, ok, 0);

    // Reset two cycles into a scan: outputs clear at once, no done follows.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h1234;
    bus.b     = 16'h1235;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async", int'({bus.busy, bus.done, bus.a_eq_b, bus.a_ls_b, bus.a_gt_b}), 0);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) pulses++;
    end
    chk("rst_no_done", pulses, 0);
    run_op("post_rst", vecs[2]);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
